// File: rtl/oai_out_edge_monitor_pkg.sv
// Shared types and helpers for the edge monitor: output stream FSM states
// and the width rule for the debounce stability counter.
package oai_out_edge_monitor_pkg;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } out_state_e;

    // Stability counter must count 0..deb-1; keep at least one bit so DEB=1 is legal.
    function automatic int stab_width(input int deb);
        return (deb > 1) ? $clog2(deb) : 1;
    endfunction

endpackage

// File: rtl/oai_out_edge_monitor_if.sv
// Snapshot stream between the edge monitor (master) and the status collector (slave).
interface oai_out_edge_monitor_if #(
    parameter int CNT_W = 8
);
    logic             cnt_val;
    logic             cnt_rdy;
    logic [CNT_W-1:0] cnt_msg;

    modport master (output cnt_val, output cnt_msg, input  cnt_rdy);
    modport slave  (input  cnt_val, input  cnt_msg, output cnt_rdy);
endinterface

// File: rtl/oai_out_edge_monitor_sig_debounce.sv
// Synchronises an asynchronous gate output, debounces it into a clean level
// and produces registered one-cycle rise/fall pulses aligned with level changes.
module oai_out_edge_monitor_sig_debounce
    import oai_out_edge_monitor_pkg::*;
#(
    parameter int NSYNC = 2,
    parameter int DEB   = 3
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sig_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);
    localparam int STAB_W = stab_width(DEB);
    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(DEB - 1);

    logic [NSYNC-1:0]  sync_q, sync_d;
    logic [STAB_W-1:0] stab_q, stab_d;
    logic              level_q, level_d;
    logic              rise_q, rise_d;
    logic              fall_q, fall_d;
    logic              s;

    assign s      = sync_q[NSYNC-1];
    assign sync_d = {sync_q[NSYNC-2:0], sig_i};

    // Debounce: a mismatch must persist DEB consecutive cycles before level follows it.
    always_comb begin
        level_d = level_q;
        stab_d  = '0;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (s != level_q) begin
            if (stab_q == STAB_LAST) begin
                level_d = s;
                rise_d  = s;
                fall_d  = ~s;
            end else begin
                stab_d = stab_q + 1'b1;
            end
        end
    end

    // Sync chain, debounce state and edge pulses.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q  <= '0;
            stab_q  <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            stab_q  <= stab_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign level_o = level_q;
    assign rise_o  = rise_q;
    assign fall_o  = fall_q;

endmodule

// File: rtl/oai_out_edge_monitor.sv
// Edge monitor for a single gate output: debounced level, edge pulses,
// saturating rising-edge counter and a val/rdy snapshot stream.
module oai_out_edge_monitor
    import oai_out_edge_monitor_pkg::*;
#(
    parameter int NSYNC = 2,
    parameter int DEB   = 3,
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic sig_in,
    input  logic cnt_en,
    input  logic flush,
    output logic level,
    output logic rise,
    output logic fall,
    output logic ovf,
    oai_out_edge_monitor_if.master cnt
);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    out_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] msg_q;
    logic             ovf_q;
    logic             inc;
    logic             sat;
    logic             accept;

    oai_out_edge_monitor_sig_debounce #(
        .NSYNC (NSYNC),
        .DEB   (DEB)
    ) u_deb (
        .clk_i   (clk),
        .rst_i   (reset),
        .sig_i   (sig_in),
        .level_o (level),
        .rise_o  (rise),
        .fall_o  (fall)
    );

    assign inc    = rise & cnt_en;
    assign sat    = (cnt_q == '1);
    // A flush only lands when the slot is free or is being emptied this cycle.
    assign accept = flush & ((state_q == ST_EMPTY) | cnt.cnt_rdy);

    // Counter, overflow flag and snapshot FSM; an edge coinciding with an
    // accepted flush opens the new window at 1 so it is not lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_EMPTY;
            cnt_q   <= '0;
            msg_q   <= '0;
            ovf_q   <= 1'b0;
        end else if (accept) begin
            state_q <= ST_FULL;
            msg_q   <= cnt_q;
            cnt_q   <= inc ? CNT_ONE : '0;
            ovf_q   <= 1'b0;
        end else begin
            if (state_q == ST_FULL && cnt.cnt_rdy)
                state_q <= ST_EMPTY;
            if (inc) begin
                if (sat)
                    ovf_q <= 1'b1;
                else
                    cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign cnt.cnt_val = (state_q == ST_FULL);
    assign cnt.cnt_msg = msg_q;
    assign ovf         = ovf_q;

endmodule

// File: tb/tb_oai_out_edge_monitor.sv
// Self-checking bench: default instance (CNT_W=8) plus a CNT_W=2 instance for
// saturation; snapshot expectations come from a bench-side counter model.
module tb_oai_out_edge_monitor;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic sig_in = 1'b0;
    logic cnt_en = 1'b1;
    logic flush = 1'b0;
    logic cnt_rdy = 1'b1;
    logic level, rise, fall, ovf;
    logic level2, rise2, fall2, ovf2;

    int n_checks = 0;
    int n_fail = 0;
    int q[$];
    int q2[$];
    int m_cnt = 0;
    int m_cnt2 = 0;
    int r2_seen = 0;
    int f2_seen = 0;

    oai_out_edge_monitor_if #(.CNT_W(8)) cnt_if ();
    oai_out_edge_monitor_if #(.CNT_W(2)) cnt_if2 ();
    assign cnt_if.cnt_rdy  = cnt_rdy;
    assign cnt_if2.cnt_rdy = cnt_rdy;

    oai_out_edge_monitor #(.NSYNC(2), .DEB(3), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .sig_in(sig_in), .cnt_en(cnt_en), .flush(flush),
        .level(level), .rise(rise), .fall(fall), .ovf(ovf), .cnt(cnt_if)
    );

    oai_out_edge_monitor #(.NSYNC(2), .DEB(3), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .sig_in(sig_in), .cnt_en(cnt_en), .flush(flush),
        .level(level2), .rise(rise2), .fall(fall2), .ovf(ovf2), .cnt(cnt_if2)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        sig_in = 1'b0;
        flush = 1'b0;
        cnt_en = 1'b1;
        cnt_rdy = 1'b1;
        q.delete();
        q2.delete();
        m_cnt = 0;
        m_cnt2 = 0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
    endtask

    // One full clean pulse on sig_in; updates the bench counter models.
    task automatic make_edge();
        sig_in = 1'b1;
        repeat (8) begin
            tick();
            if (rise2) r2_seen++;
        end
        sig_in = 1'b0;
        repeat (8) begin
            tick();
            if (fall2) f2_seen++;
        end
        if (cnt_en) begin
            m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
            m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
        end
    endtask

    task automatic test_reset();
        int e;
        do_reset();
        sig_in = 1'b1;
        repeat (8) tick();
        m_cnt = 1;
        flush = 1'b1;
        q.push_back(m_cnt);
        m_cnt = 0;
        tick();
        flush = 1'b0;
        @(negedge clk);
        n_checks++;
        if (level !== 1'b1 || cnt_if.cnt_val !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pre: got level=%b val=%b want 1 1", level, cnt_if.cnt_val);
        end
        n_checks++;
        if (q.size() == 0) begin
            n_fail++;
            $display("FAIL reset_pre_msg: got empty queue want one entry");
        end else begin
            e = q.pop_front();
            if (cnt_if.cnt_msg !== e[7:0]) begin
                n_fail++;
                $display("FAIL reset_pre_msg: got %0d want %0d", cnt_if.cnt_msg, e);
            end
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({level, rise, fall, ovf, cnt_if.cnt_val, cnt_if.cnt_msg} !== 12'h0) begin
            n_fail++;
            $display("FAIL reset_async: got level=%b rise=%b fall=%b ovf=%b val=%b msg=%0d want all 0",
                     level, rise, fall, ovf, cnt_if.cnt_val, cnt_if.cnt_msg);
        end
        sig_in = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (20) begin
            @(negedge clk);
            n_checks++;
            if ({level, rise, fall, cnt_if.cnt_val} !== 4'b0) begin
                n_fail++;
                $display("FAIL reset_idle: got level=%b rise=%b fall=%b val=%b want 0 0 0 0",
                         level, rise, fall, cnt_if.cnt_val);
            end
        end
        tick();
    endtask

    task automatic test_clean_rise();
        int e;
        sig_in = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            n_checks++;
            if (k < 4 && {level, rise} !== 2'b00) begin
                n_fail++;
                $display("FAIL rise_early edge%0d: got level=%b rise=%b want 0 0", k, level, rise);
            end else if (k == 4 && {level, rise, fall} !== 3'b110) begin
                n_fail++;
                $display("FAIL rise_edge4: got level=%b rise=%b fall=%b want 1 1 0", level, rise, fall);
            end
        end
        @(negedge clk);
        n_checks++;
        if ({level, rise} !== 2'b10) begin
            n_fail++;
            $display("FAIL rise_pulse_end: got level=%b rise=%b want 1 0", level, rise);
        end
        tick();
        repeat (3) tick();
        m_cnt++;
        sig_in = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            @(negedge clk);
            n_checks++;
            if (k < 4 && {level, fall} !== 2'b10) begin
                n_fail++;
                $display("FAIL fall_early edge%0d: got level=%b fall=%b want 1 0", k, level, fall);
            end else if (k == 4 && {level, rise, fall} !== 3'b001) begin
                n_fail++;
                $display("FAIL fall_edge4: got level=%b rise=%b fall=%b want 0 0 1", level, rise, fall);
            end
        end
        @(negedge clk);
        n_checks++;
        if (fall !== 1'b0) begin
            n_fail++;
            $display("FAIL fall_pulse_end: got %b want 0", fall);
        end
        tick();
        flush = 1'b1;
        q.push_back(m_cnt);
        m_cnt = 0;
        tick();
        flush = 1'b0;
        @(negedge clk);
        n_checks++;
        e = (q.size() > 0) ? q.pop_front() : -1;
        if (cnt_if.cnt_val !== 1'b1 || e < 0 || cnt_if.cnt_msg !== e[7:0]) begin
            n_fail++;
            $display("FAIL clean_count: got val=%b msg=%0d want 1 %0d", cnt_if.cnt_val, cnt_if.cnt_msg, e);
        end
        tick();
        @(negedge clk);
        n_checks++;
        if (cnt_if.cnt_val !== 1'b0) begin
            n_fail++;
            $display("FAIL clean_drain: got val=%b want 0", cnt_if.cnt_val);
        end
        tick();
    endtask

    task automatic test_glitch();
        int seen, r, f, e;
        seen = 0;
        r = 0;
        f = 0;
        sig_in = 1'b1;
        repeat (2) tick();
        sig_in = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (rise || level || fall) seen++;
        end
        tick();
        n_checks++;
        if (seen != 0) begin
            n_fail++;
            $display("FAIL glitch_2cyc: got %0d active cycles want 0", seen);
        end
        sig_in = 1'b1;
        repeat (3) tick();
        sig_in = 1'b0;
        repeat (16) begin
            @(negedge clk);
            if (rise) r++;
            if (fall) f++;
        end
        tick();
        if (cnt_en) m_cnt++;
        n_checks++;
        if (r != 1 || f != 1) begin
            n_fail++;
            $display("FAIL glitch_3cyc: got rises=%0d falls=%0d want 1 1", r, f);
        end
        flush = 1'b1;
        q.push_back(m_cnt);
        m_cnt = 0;
        tick();
        flush = 1'b0;
        @(negedge clk);
        n_checks++;
        e = (q.size() > 0) ? q.pop_front() : -1;
        if (cnt_if.cnt_val !== 1'b1 || e < 0 || cnt_if.cnt_msg !== e[7:0]) begin
            n_fail++;
            $display("FAIL glitch_count: got val=%b msg=%0d want 1 %0d", cnt_if.cnt_val, cnt_if.cnt_msg, e);
        end
        tick();
    endtask

    task automatic test_saturation();
        int e;
        do_reset();
        r2_seen = 0;
        f2_seen = 0;
        for (int k = 0; k < 4; k++) begin
            make_edge();
            if (k == 2) begin
                n_checks++;
                if (ovf2 !== 1'b0) begin
                    n_fail++;
                    $display("FAIL sat_3rise_ovf: got %b want 0", ovf2);
                end
            end
        end
        n_checks++;
        if (ovf2 !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_4rise_ovf: got %b want 1", ovf2);
        end
        n_checks++;
        if (r2_seen != 4 || f2_seen != 4 || level2 !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_pulses: got rises=%0d falls=%0d level=%b want 4 4 0", r2_seen, f2_seen, level2);
        end
        flush = 1'b1;
        q2.push_back(m_cnt2);
        m_cnt2 = 0;
        tick();
        flush = 1'b0;
        @(negedge clk);
        n_checks++;
        e = (q2.size() > 0) ? q2.pop_front() : -1;
        if (cnt_if2.cnt_val !== 1'b1 || e < 0 || cnt_if2.cnt_msg !== e[1:0] || ovf2 !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_flush: got val=%b msg=%0d ovf=%b want 1 %0d 0",
                     cnt_if2.cnt_val, cnt_if2.cnt_msg, ovf2, e);
        end
        tick();
        flush = 1'b1;
        q2.push_back(m_cnt2);
        tick();
        flush = 1'b0;
        @(negedge clk);
        n_checks++;
        e = (q2.size() > 0) ? q2.pop_front() : -1;
        if (cnt_if2.cnt_val !== 1'b1 || e < 0 || cnt_if2.cnt_msg !== e[1:0]) begin
            n_fail++;
            $display("FAIL sat_cleared: got val=%b msg=%0d want 1 %0d", cnt_if2.cnt_val, cnt_if2.cnt_msg, e);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int e;
        do_reset();
        repeat (5) make_edge();
        flush = 1'b1;
        cnt_rdy = 1'b0;
        q.push_back(m_cnt);
        m_cnt = 0;
        tick();
        flush = 1'b0;
        @(negedge clk);
        n_checks++;
        e = (q.size() > 0) ? q.pop_front() : -1;
        if (cnt_if.cnt_val !== 1'b1 || e < 0 || cnt_if.cnt_msg !== e[7:0]) begin
            n_fail++;
            $display("FAIL bp_first: got val=%b msg=%0d want 1 %0d", cnt_if.cnt_val, cnt_if.cnt_msg, e);
        end
        tick();
        repeat (2) make_edge();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge clk);
        n_checks++;
        if (cnt_if.cnt_val !== 1'b1 || cnt_if.cnt_msg !== 8'd5) begin
            n_fail++;
            $display("FAIL bp_ignored: got val=%b msg=%0d want 1 5", cnt_if.cnt_val, cnt_if.cnt_msg);
        end
        tick();
        cnt_rdy = 1'b1;
        flush = 1'b1;
        q.push_back(m_cnt);
        m_cnt = 0;
        tick();
        flush = 1'b0;
        @(negedge clk);
        n_checks++;
        e = (q.size() > 0) ? q.pop_front() : -1;
        if (cnt_if.cnt_val !== 1'b1 || e < 0 || cnt_if.cnt_msg !== e[7:0]) begin
            n_fail++;
            $display("FAIL bp_release: got val=%b msg=%0d want 1 %0d", cnt_if.cnt_val, cnt_if.cnt_msg, e);
        end
        tick();
    endtask

    task automatic test_same_cycle();
        int e;
        do_reset();
        for (int pass = 0; pass < 2; pass++) begin
            repeat (4) make_edge();
            sig_in = 1'b1;
            repeat (5) tick();
            cnt_en = (pass == 0);
            n_checks++;
            if (rise !== 1'b1) begin
                n_fail++;
                $display("FAIL same_rise_align pass%0d: got %b want 1", pass, rise);
            end
            flush = 1'b1;
            q.push_back(m_cnt);
            m_cnt = cnt_en ? 1 : 0;
            tick();
            flush = 1'b0;
            cnt_en = 1'b1;
            @(negedge clk);
            n_checks++;
            e = (q.size() > 0) ? q.pop_front() : -1;
            if (cnt_if.cnt_val !== 1'b1 || e < 0 || cnt_if.cnt_msg !== e[7:0]) begin
                n_fail++;
                $display("FAIL same_snap pass%0d: got val=%b msg=%0d want 1 %0d",
                         pass, cnt_if.cnt_val, cnt_if.cnt_msg, e);
            end
            tick();
            repeat (3) tick();
            sig_in = 1'b0;
            repeat (8) tick();
            flush = 1'b1;
            q.push_back(m_cnt);
            m_cnt = 0;
            tick();
            flush = 1'b0;
            @(negedge clk);
            n_checks++;
            e = (q.size() > 0) ? q.pop_front() : -1;
            if (cnt_if.cnt_val !== 1'b1 || e < 0 || cnt_if.cnt_msg !== e[7:0]) begin
                n_fail++;
                $display("FAIL same_carry pass%0d: got val=%b msg=%0d want 1 %0d",
                         pass, cnt_if.cnt_val, cnt_if.cnt_msg, e);
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_clean_rise();
        test_glitch();
        test_saturation();
        test_backpressure();
        test_same_cycle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
